oldland_decode_pipe: RTL and testbench

- Parametrised next-generation decode stage between fetch and execute.
- Keeps the existing Oldland field decode: ra/rb/rd selects, immediates, ALU opcode/operand selects, load/store, memory width, branch condition, call, flags update.
- Adds a valid/ready handshake on both sides, a pipeline flush, a load-use interlock and a stall counter.
- Register-select width and link register are parametrised so the block serves the wider register-file variant.

---
 rtl/oldland_decode_pipe_if.sv | 48 ++++
 rtl/oldland_decode_pipe.sv | 243 ++++++++++++++++++++++++
 tb/tb_oldland_decode_pipe.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oldland_decode_pipe_if.sv
// Fetch/decode/execute handshake and decoded bundle for oldland_decode_pipe.
// master = fetch+execute side, slave = the decode stage.
interface oldland_decode_pipe_if #(
  parameter int unsigned REG_SEL_W   = 3,
  parameter int unsigned STALL_CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            instr;
  logic [31:0]            pc_plus_4;
  logic                   flush;
  logic [REG_SEL_W-1:0]   ra_sel;
  logic [REG_SEL_W-1:0]   rb_sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [REG_SEL_W-1:0]   rd_sel;
  logic                   update_rd;
  logic                   update_flags;
  logic [31:0]            imm32;
  logic [3:0]             alu_opc;
  logic [2:0]             branch_condition;
  logic                   alu_op1_ra;
  logic                   alu_op2_rb;
  logic                   mem_load;
  logic                   mem_store;
  logic [1:0]             mem_width;
  logic [1:0]             instr_class;
  logic                   is_call;
  logic [31:0]            pc_plus_4_out;
  logic                   illegal;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output in_valid, instr, pc_plus_4, flush, out_ready,
    input  in_ready, ra_sel, rb_sel, out_valid, rd_sel, update_rd,
           update_flags, imm32, alu_opc, branch_condition, alu_op1_ra,
           alu_op2_rb, mem_load, mem_store, mem_width, instr_class,
           is_call, pc_plus_4_out, illegal, stall_count
  );

  modport slave (
    input  in_valid, instr, pc_plus_4, flush, out_ready,
    output in_ready, ra_sel, rb_sel, out_valid, rd_sel, update_rd,
           update_flags, imm32, alu_opc, branch_condition, alu_op1_ra,
           alu_op2_rb, mem_load, mem_store, mem_width, instr_class,
           is_call, pc_plus_4_out, illegal, stall_count
  );
endinterface

// File: rtl/oldland_decode_pipe.sv
// Oldland decode stage with valid/ready on both sides, flush, load-use interlock
// and saturating stall counter. Optional trap decode: OLDLAND_DECODE_ILLEGAL_EN.
module oldland_decode_pipe #(
  parameter int unsigned REG_SEL_W   = 3,
  parameter int unsigned LINK_REG    = 6,
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  oldland_decode_pipe_if.slave bus
);

  localparam logic [1:0] CLASS_ARITH  = 2'b00;
  localparam logic [1:0] CLASS_BRANCH = 2'b01;
  localparam logic [1:0] CLASS_MEM    = 2'b10;

  localparam logic [3:0] OPCODE_MOVHI = 4'b1010;
  localparam logic [3:0] OPCODE_CMP   = 4'b1011;

  localparam logic [3:0] OPCODE_CALL  = 4'b0000;
  localparam logic [3:0] OPCODE_RET   = 4'b0001;
  localparam logic [3:0] OPCODE_BNE   = 4'b0101;
  localparam logic [3:0] OPCODE_BEQ   = 4'b0110;
  localparam logic [3:0] OPCODE_BGT   = 4'b0111;
  localparam logic [3:0] OPCODE_BLT   = 4'b1000;

  localparam logic [REG_SEL_W-1:0] LINK_SEL = REG_SEL_W'(LINK_REG);

  logic [31:0]          w_instr;
  logic [1:0]           w_class;
  logic [3:0]           w_opc;
  logic                 w_is_branch;
  logic                 w_is_mem;
  logic                 w_is_arith;
  logic                 w_is_ret;
  logic                 w_reg_jump;
  logic                 w_reads_ra;
  logic                 w_reads_rb;
  logic [REG_SEL_W-1:0] w_ra_field;
  logic [REG_SEL_W-1:0] w_rb_field;
  logic [REG_SEL_W-1:0] w_rd_field;
  logic [REG_SEL_W-1:0] w_ra_sel;
  logic                 w_hazard;
  logic                 w_in_ready;
  logic                 w_accept;

  logic                 w_update_rd;
  logic                 w_update_flags;
  logic [31:0]          w_imm32;
  logic [3:0]           w_alu_opc;
  logic [2:0]           w_branch_condition;
  logic                 w_alu_op1_ra;
  logic                 w_alu_op2_rb;
  logic                 w_mem_load;
  logic                 w_mem_store;
  logic [1:0]           w_mem_width;
  logic                 w_is_call;
  logic                 w_illegal;

  logic                   r_out_valid;
  logic [REG_SEL_W-1:0]   r_rd_sel;
  logic                   r_update_rd;
  logic                   r_update_flags;
  logic [31:0]            r_imm32;
  logic [3:0]             r_alu_opc;
  logic [2:0]             r_branch_condition;
  logic                   r_alu_op1_ra;
  logic                   r_alu_op2_rb;
  logic                   r_mem_load;
  logic                   r_mem_store;
  logic [1:0]             r_mem_width;
  logic [1:0]             r_instr_class;
  logic                   r_is_call;
  logic [31:0]            r_pc_plus_4;
  logic                   r_illegal;
  logic [STALL_CNT_W-1:0] r_stall_count;

  assign w_instr = bus.instr;
  assign w_class = w_instr[31:30];
  assign w_opc   = w_instr[29:26];

  // Wider register files keep the legacy low bits and stack the extra bits above.
  generate
    if (REG_SEL_W > 3) begin : g_wide_sel
      assign w_rd_field = {w_instr[9  +: REG_SEL_W-3], w_instr[8:6]};
      assign w_ra_field = {w_instr[12 +: REG_SEL_W-3], w_instr[5:3]};
      assign w_rb_field = {w_instr[15 +: REG_SEL_W-3], w_instr[2:0]};
    end else begin : g_narrow_sel
      assign w_rd_field = w_instr[8:6];
      assign w_ra_field = w_instr[5:3];
      assign w_rb_field = w_instr[2:0];
    end
  endgenerate

  // Anything not branch/mem decodes down the arithmetic path, as the legacy logic did.
  assign w_is_branch = (w_class == CLASS_BRANCH);
  assign w_is_mem    = (w_class == CLASS_MEM);
  assign w_is_arith  = !w_is_branch && !w_is_mem;
  assign w_is_ret    = w_is_branch && (w_opc == OPCODE_RET);
  assign w_reg_jump  = w_is_branch && w_instr[25];

  assign w_ra_sel   = w_is_ret ? LINK_SEL : w_ra_field;
  assign w_reads_ra = w_is_arith || w_is_mem || w_reg_jump || w_is_ret;
  assign w_reads_rb = (w_is_arith && w_instr[9]) || (w_is_mem && w_instr[28]);

  always_comb begin
    w_update_rd        = w_is_arith && (w_opc != OPCODE_CMP);
    w_update_flags     = w_is_arith && (w_opc == OPCODE_CMP);
    w_alu_opc          = '0;
    w_branch_condition = '0;
    w_alu_op1_ra       = w_is_arith || w_is_mem || w_reg_jump;
    w_alu_op2_rb       = w_is_arith && w_instr[9];
    w_mem_load         = w_is_mem && !w_instr[28];
    w_mem_store        = w_is_mem && w_instr[28];
    w_is_call          = w_is_branch && (w_opc == OPCODE_CALL);
    w_illegal          = 1'b0;

    if (w_is_arith)
      w_alu_opc = w_opc;
    else if (w_reg_jump)
      w_alu_opc = '1;

    if (w_is_branch) begin
      unique case (w_opc)
        OPCODE_BNE: w_branch_condition = 3'b001;
        OPCODE_BEQ: w_branch_condition = 3'b010;
        OPCODE_BGT: w_branch_condition = 3'b011;
        OPCODE_BLT: w_branch_condition = 3'b100;
        default:    w_branch_condition = 3'b111;
      endcase
    end

    if (w_is_branch)
      w_imm32 = {{6{w_instr[23]}}, w_instr[23:0], 2'b00};
    else if (w_is_arith && (w_opc == OPCODE_MOVHI))
      w_imm32 = {w_instr[25:10], 16'h0000};
    else
      w_imm32 = {{16{w_instr[25]}}, w_instr[25:10]};

    unique case (w_instr[27:26])
      2'b00:   w_mem_width = 2'b10;
      2'b01:   w_mem_width = 2'b01;
      default: w_mem_width = 2'b00;
    endcase

`ifdef OLDLAND_DECODE_ILLEGAL_EN
    w_illegal = !(w_class inside {CLASS_ARITH, CLASS_BRANCH, CLASS_MEM});
    if (w_illegal) begin
      w_update_rd    = 1'b0;
      w_update_flags = 1'b0;
      w_mem_load     = 1'b0;
      w_mem_store    = 1'b0;
      w_is_call      = 1'b0;
    end
`endif
  end

  // Load-use: the held load's destination is not yet written when the next
  // instruction reads the register file, so hold that instruction one cycle.
  assign w_hazard = r_out_valid && r_mem_load && bus.in_valid &&
                    ((w_reads_ra && (w_ra_sel   == r_rd_sel)) ||
                     (w_reads_rb && (w_rb_field == r_rd_sel)));

  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sel           <= '0;
      r_update_rd        <= 1'b0;
      r_update_flags     <= 1'b0;
      r_imm32            <= '0;
      r_alu_opc          <= '0;
      r_branch_condition <= '0;
      r_alu_op1_ra       <= 1'b0;
      r_alu_op2_rb       <= 1'b0;
      r_mem_load         <= 1'b0;
      r_mem_store        <= 1'b0;
      r_mem_width        <= '0;
      r_instr_class      <= '0;
      r_is_call          <= 1'b0;
      r_pc_plus_4        <= '0;
      r_illegal          <= 1'b0;
    end else if (w_accept) begin
      r_rd_sel           <= w_rd_field;
      r_update_rd        <= w_update_rd;
      r_update_flags     <= w_update_flags;
      r_imm32            <= w_imm32;
      r_alu_opc          <= w_alu_opc;
      r_branch_condition <= w_branch_condition;
      r_alu_op1_ra       <= w_alu_op1_ra;
      r_alu_op2_rb       <= w_alu_op2_rb;
      r_mem_load         <= w_mem_load;
      r_mem_store        <= w_mem_store;
      r_mem_width        <= w_mem_width;
      r_instr_class      <= w_class;
      r_is_call          <= w_is_call;
      r_pc_plus_4        <= bus.pc_plus_4;
      r_illegal          <= w_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_count <= '0;
    else if (w_hazard && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 1'b1;
  end

  assign bus.in_ready         = w_in_ready;
  assign bus.ra_sel           = w_ra_sel;
  assign bus.rb_sel           = w_rb_field;
  assign bus.out_valid        = r_out_valid;
  assign bus.rd_sel           = r_rd_sel;
  assign bus.update_rd        = r_update_rd;
  assign bus.update_flags     = r_update_flags;
  assign bus.imm32            = r_imm32;
  assign bus.alu_opc          = r_alu_opc;
  assign bus.branch_condition = r_branch_condition;
  assign bus.alu_op1_ra       = r_alu_op1_ra;
  assign bus.alu_op2_rb       = r_alu_op2_rb;
  assign bus.mem_load         = r_mem_load;
  assign bus.mem_store        = r_mem_store;
  assign bus.mem_width        = r_mem_width;
  assign bus.instr_class      = r_instr_class;
  assign bus.is_call          = r_is_call;
  assign bus.pc_plus_4_out    = r_pc_plus_4;
  assign bus.illegal          = r_illegal;
  assign bus.stall_count      = r_stall_count;

endmodule

// File: tb/tb_oldland_decode_pipe.sv
// Scoreboard bench for oldland_decode_pipe: directed scenarios then random traffic
// against a transaction-level reference of the decode rules and handshake.
module tb_oldland_decode_pipe;

  localparam int unsigned RW     = 3;
  localparam int unsigned LINK   = 6;
  localparam int unsigned SCW    = 4;
  localparam int unsigned SATMAX = (1 << SCW) - 1;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic          update_rd;
    logic          update_flags;
    logic [31:0]   imm32;
    logic [3:0]    alu_opc;
    logic [2:0]    bc;
    logic          op1;
    logic          op2;
    logic          load;
    logic          store;
    logic [1:0]    width;
    logic [1:0]    cls;
    logic          call;
    logic [31:0]   pc;
    logic          illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oldland_decode_pipe_if #(.REG_SEL_W(RW), .STALL_CNT_W(SCW)) bus ();

  oldland_decode_pipe #(.REG_SEL_W(RW), .LINK_REG(LINK), .STALL_CNT_W(SCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t        q[$];
  bit          m_held;
  bit          m_held_load;
  logic [RW-1:0] m_held_rd;
  int unsigned m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode written from the ISA rules (classes 00 arith, 01 branch, 10 mem).
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int s;
    int unsigned cls;
    int unsigned op;
    bit br, mem, ar, rj;
    cls = ins[31:30];
    op  = ins[29:26];
    br  = (cls == 1);
    mem = (cls == 2);
    ar  = !br && !mem;
    rj  = br && ins[25];
    e = '0;
    e.rd = ins[8:6];
    e.cls = ins[31:30];
    e.pc = pc;
    e.update_rd = ar && (op != 11);
    e.update_flags = ar && (op == 11);
    e.alu_opc = ar ? 4'(op) : (rj ? 4'd15 : 4'd0);
    if (br) begin
      case (op)
        5: e.bc = 3'd1;
        6: e.bc = 3'd2;
        7: e.bc = 3'd3;
        8: e.bc = 3'd4;
        default: e.bc = 3'd7;
      endcase
      s = $signed(ins[23:0]);
      e.imm32 = 32'(s * 4);
    end else if (ar && op == 10) begin
      e.imm32 = 32'(ins[25:10]) * 32'd65536;
    end else begin
      s = $signed(ins[25:10]);
      e.imm32 = 32'(s);
    end
    e.op1 = ar || mem || rj;
    e.op2 = ar && ins[9];
    e.load = mem && !ins[28];
    e.store = mem && ins[28];
    e.width = (ins[27:26] == 2'd0) ? 2'd2 : ((ins[27:26] == 2'd1) ? 2'd1 : 2'd0);
    e.call = br && (op == 0);
`ifdef OLDLAND_DECODE_ILLEGAL_EN
    if (cls == 3) begin
      e.illegal = 1'b1;
      e.update_rd = 1'b0;
      e.update_flags = 1'b0;
      e.load = 1'b0;
      e.store = 1'b0;
      e.call = 1'b0;
    end
`endif
    return e;
  endfunction

  function automatic logic [RW-1:0] ref_ra(input logic [31:0] ins);
    return (ins[31:30] == 2'd1 && ins[29:26] == 4'd1) ? RW'(LINK) : ins[5:3];
  endfunction

  function automatic bit reads_ra(input logic [31:0] ins);
    bit br = (ins[31:30] == 2'd1);
    return !br || (br && ins[25]) || (br && ins[29:26] == 4'd1);
  endfunction

  function automatic bit reads_rb(input logic [31:0] ins);
    bit br = (ins[31:30] == 2'd1);
    bit mem = (ins[31:30] == 2'd2);
    return (!br && !mem && ins[9]) || (mem && ins[28]);
  endfunction

  // One cycle of stimulus: drive, compare handshake against the model, advance the model.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit fl, input bit ordy);
    bit hz, rdy;
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.instr = ins;
    bus.pc_plus_4 = pc;
    bus.flush = fl;
    bus.out_ready = ordy;
    #1;
    hz = m_held && m_held_load && v &&
         ((reads_ra(ins) && ref_ra(ins) == m_held_rd) ||
          (reads_rb(ins) && ins[2:0] == m_held_rd));
    rdy = (!m_held || ordy) && !hz && !fl;
    check("out_valid", 64'(bus.out_valid), 64'(m_held));
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    check("stall_count", 64'(bus.stall_count), 64'(m_stall));
    check("ra_sel", 64'(bus.ra_sel), 64'(ref_ra(ins)));
    check("rb_sel", 64'(bus.rb_sel), 64'(ins[2:0]));
    if (hz && m_stall < SATMAX) m_stall++;
    if (fl) begin
      if (m_held) void'(q.pop_front());
      m_held = 1'b0;
    end else if (v && rdy) begin
      e = ref_decode(ins, pc);
      q.push_back(e);
      m_held = 1'b1;
      m_held_load = e.load;
      m_held_rd = e.rd;
    end else if (ordy) begin
      m_held = 1'b0;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_held = 1'b0;
    m_held_load = 1'b0;
    m_held_rd = '0;
    m_stall = 0;
  endtask

  // Monitor: every presented bundle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && !bus.flush) begin
      if (q.size() == 0) begin
        check("unexpected_bundle", 64'(1), 64'(0));
      end else begin
        e = q[0];
        check("rd_sel", 64'(bus.rd_sel), 64'(e.rd));
        check("imm32", 64'(bus.imm32), 64'(e.imm32));
        check("ctrl", 64'({bus.update_rd, bus.update_flags, bus.alu_opc, bus.branch_condition,
                           bus.alu_op1_ra, bus.alu_op2_rb, bus.mem_load, bus.mem_store,
                           bus.mem_width, bus.instr_class, bus.is_call, bus.illegal}),
                      64'({e.update_rd, e.update_flags, e.alu_opc, e.bc, e.op1, e.op2,
                           e.load, e.store, e.width, e.cls, e.call, e.illegal}));
        check("pc_plus_4_out", 64'(bus.pc_plus_4_out), 64'(e.pc));
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if (w[31:30] == 2'd1) w[29:26] = 4'($urandom_range(0, 8));
    w[8:6] = 3'($urandom_range(0, 3));
    w[5:3] = 3'($urandom_range(0, 3));
    w[2:0] = 3'($urandom_range(0, 3));
    return w;
  endfunction

  localparam logic [31:0] I_ADD   = 32'h0000_02CA;  // ADD r3 <- r1, r2 (rb form)
  localparam logic [31:0] I_MOVHI = 32'h2848_D100;  // MOVHI r4, 0x1234
  localparam logic [31:0] I_LDR2  = 32'h8000_00A8;  // LDR32 r2, [r5]
  localparam logic [31:0] I_USE2  = 32'h0000_0050;  // ADD r1 <- r2, imm
  localparam logic [31:0] I_BEQ   = 32'h58FF_FFFF;  // BEQ offset -1
  localparam logic [31:0] I_UNDEF = 32'hC000_00CA;  // class 11, ADD-like, rd r3

  initial begin
    bit v, fl, ordy;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.pc_plus_4 = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_imm32", 64'(bus.imm32), 64'(0));
    check("rst_stall", 64'(bus.stall_count), 64'(0));
    check("rst_pc", 64'(bus.pc_plus_4_out), 64'(0));
    check("rst_update_rd", 64'(bus.update_rd), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ADD then MOVHI, no bubbles.
    step(1, I_ADD, 32'h104, 0, 1);
    step(1, I_MOVHI, 32'h108, 0, 1);
    check("add_op2_rb", 64'(bus.alu_op2_rb), 64'(1));
    step(0, 32'h0, 32'h0, 0, 1);
    check("movhi_imm", 64'(bus.imm32), 64'h1234_0000);
    check("movhi_valid", 64'(bus.out_valid), 64'(1));

    // Load-use interlock: one bubble.
    step(1, I_LDR2, 32'h200, 0, 1);
    step(1, I_USE2, 32'h204, 0, 1);
    check("hazard_in_ready", 64'(bus.in_ready), 64'(0));
    step(1, I_USE2, 32'h204, 0, 1);
    check("bubble", 64'(bus.out_valid), 64'(0));
    check("stall_one", 64'(bus.stall_count), 64'(1));
    step(0, 32'h0, 32'h0, 0, 1);
    check("use_after_bubble", 64'(bus.out_valid), 64'(1));

    // Backpressure for three cycles.
    step(1, I_ADD, 32'h300, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, I_MOVHI, 32'h304, 0, 0);
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    end
    step(1, I_MOVHI, 32'h304, 0, 1);

    // Flush drops pending and incoming; then BEQ -1.
    step(1, I_ADD, 32'h400, 0, 0);
    step(1, I_MOVHI, 32'h404, 1, 0);
    check("flush_in_ready", 64'(bus.in_ready), 64'(0));
    step(1, I_BEQ, 32'h500, 0, 1);
    check("flush_dropped", 64'(bus.out_valid), 64'(0));
    step(0, 32'h0, 32'h0, 0, 1);
    check("beq_cond", 64'(bus.branch_condition), 64'(3'b010));
    check("beq_imm", 64'(bus.imm32), 64'hFFFF_FFFC);

    // Undefined class.
    step(1, I_UNDEF, 32'h600, 0, 1);
    step(0, 32'h0, 32'h0, 0, 1);
`ifdef OLDLAND_DECODE_ILLEGAL_EN
    check("undef_illegal", 64'(bus.illegal), 64'(1));
    check("undef_update_rd", 64'(bus.update_rd), 64'(0));
`else
    check("undef_illegal", 64'(bus.illegal), 64'(0));
    check("undef_update_rd", 64'(bus.update_rd), 64'(1));
`endif
    check("undef_store", 64'(bus.mem_store), 64'(0));

    // Hazard coinciding with flush still counts.
    step(1, I_LDR2, 32'h700, 0, 1);
    step(1, I_USE2, 32'h704, 1, 1);
    step(0, 32'h0, 32'h0, 0, 1);
    check("flush_hazard_stall", 64'(bus.stall_count), 64'(2));

    // Asynchronous reset mid-stream with a held bundle.
    step(1, I_MOVHI, 32'h800, 0, 0);
    step(1, I_ADD, 32'h804, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_imm32", 64'(bus.imm32), 64'(0));
    check("async_stall", 64'(bus.stall_count), 64'(0));
    model_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic; interlock bias drives the small counter into saturation.
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, rand_instr(), $urandom, fl, ordy);
    end
    for (int i = 0; i < 4; i++) step(0, 32'h0, 32'h0, 0, 1);
    check("drained", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
